// File: rtl/mem_burst_reader_pkg.sv
// Shared types and width helpers for the burst read engine.
package mem_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Inflight counter must hold 0..depth inclusive.
  function automatic int unsigned inflight_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mem_burst_reader_sync_fifo.sv
// Return-data FIFO with a parallel last flag; pop on empty is ignored (no bypass).
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    push_last,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   pop_data,
  output logic                    pop_last,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]      last_q, last_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    data_d   = data_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      data_d[wr_ptr_q] = push_data;
      last_d[wr_ptr_q] = push_last;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
      end
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      data_q   <= data_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = data_q[rd_ptr_q];
  assign pop_last = last_q[rd_ptr_q];
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/mem_burst_reader.sv
// Credit-limited burst read engine for one shared-memory port.
// Optional stall counter enabled by MEM_BURST_READER_STATS_EN.
module mem_burst_reader
  import mem_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_avalid,
  input  logic                  r_aready,
  input  logic                  r_dvalid,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  done
`ifdef MEM_BURST_READER_STATS_EN
  ,
  output logic [15:0]           stall_cycles
`endif
);

  localparam int unsigned IW = inflight_width(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = IW + 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [LEN_WIDTH-1:0]  ret_idx_q, ret_idx_d;
  logic [IW-1:0]         inflight_q, inflight_d;
  logic                  r_avalid_q, r_avalid_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  done_q, done_d;

  logic                  cmd_hs, req_acc, ret_take, push, pop, push_last;
  logic                  fifo_empty, fifo_full, fifo_last;
  logic [CW-1:0]         fifo_count, fifo_count_d;
  logic [SW-1:0]         credit_d;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (r_data),
    .push_last (push_last),
    .pop       (pop),
    .pop_data  (out_data),
    .pop_last  (fifo_last),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    cmd_hs    = cmd_valid && cmd_ready_q;
    req_acc   = r_avalid_q && r_aready;
    ret_take  = r_dvalid && (inflight_q != '0);
    pop       = !fifo_empty && out_ready;
    push      = ret_take && (!fifo_full || pop);
    push_last = (ret_idx_q == len_q - LEN_WIDTH'(1));

    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    remaining_d = remaining_q;
    ret_idx_d   = ret_idx_q;
    done_d      = 1'b0;
    inflight_d  = inflight_q + IW'(req_acc) - IW'(ret_take);

    if (ret_take) begin
      ret_idx_d = ret_idx_q + LEN_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          addr_d      = cmd_addr;
          len_d       = cmd_len;
          remaining_d = cmd_len;
          ret_idx_d   = '0;
          if (cmd_len == '0) begin
            state_d = DRAIN;
            done_d  = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (req_acc) begin
          addr_d      = addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (len_q == '0) begin
          state_d = IDLE;
        end else if (pop && fifo_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Credit uses next-cycle occupancy so a fresh request always has a FIFO slot.
    fifo_count_d = fifo_count + CW'(push) - CW'(pop);
    credit_d     = SW'(fifo_count_d) + SW'(inflight_d);
    if (r_avalid_q && !r_aready) begin
      r_avalid_d = 1'b1;
    end else begin
      r_avalid_d = (state_d == REQ) && (remaining_d != '0) &&
                   (credit_d < SW'(FIFO_DEPTH));
    end
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      remaining_q <= '0;
      ret_idx_q   <= '0;
      inflight_q  <= '0;
      r_avalid_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      ret_idx_q   <= ret_idx_d;
      inflight_q  <= inflight_d;
      r_avalid_q  <= r_avalid_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
    end
  end

`ifdef MEM_BURST_READER_STATS_EN
  logic [15:0] stall_q, stall_d;
  logic        stall_evt;

  // Stalls: memory not accepting, or REQ idling for lack of credit.
  always_comb begin
    stall_evt = (r_avalid_q && !r_aready) ||
                ((state_q == REQ) && !r_avalid_q && (remaining_q != '0) &&
                 ((SW'(fifo_count) + SW'(inflight_q)) >= SW'(FIFO_DEPTH)));
    stall_d = stall_q;
    if (cmd_hs) begin
      stall_d = '0;
    end else if (stall_evt && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

  assign cmd_ready = cmd_ready_q;
  assign r_addr    = addr_q;
  assign r_avalid  = r_avalid_q;
  assign out_valid = !fifo_empty;
  assign out_last  = fifo_last && !fifo_empty;
  assign done      = done_q;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader with a behavioural memory port model.
module tb_mem_burst_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] r_addr;
  logic          r_avalid;
  logic          r_aready;
  logic          r_dvalid;
  logic [DW-1:0] r_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          done;
`ifdef MEM_BURST_READER_STATS_EN
  logic [15:0]   stall_cycles;
`endif

  always #5 clk = ~clk;

  mem_burst_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .r_addr    (r_addr),
    .r_avalid  (r_avalid),
    .r_aready  (r_aready),
    .r_dvalid  (r_dvalid),
    .r_data    (r_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .done      (done)
`ifdef MEM_BURST_READER_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [AW-1:0] a;
    int            due;
  } ret_t;

  int            aready_delay = 1;
  int            ret_delay    = 1;
  int            wait_cnt     = 0;
  int            cyc          = 0;
  int            stable_err   = 0;
  int            acc_total    = 0;
  int            pop_total    = 0;
  int            max_occ      = 0;
  int            done_cnt     = 0;
  logic [AW-1:0] ack_addr;
  logic [AW-1:0] held_addr;
  logic [AW-1:0] ack_log [$];
  ret_t          pend [$];
  logic [DW-1:0] out_data_log [$];
  logic          out_last_log [$];

  // Memory port model: acks after aready_delay cycles, returns data=addr*16 in order.
  initial begin
    r_aready = 1'b0;
    r_dvalid = 1'b0;
    r_data   = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      r_dvalid = 1'b0;
      if (r_aready) begin
        r_aready = 1'b0;
        wait_cnt = 0;
        ack_log.push_back(ack_addr);
        acc_total++;
        pend.push_back('{a: ack_addr, due: cyc + ret_delay - 1});
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        r_dvalid = 1'b1;
        r_data   = DW'(pend[0].a) * 16;
        void'(pend.pop_front());
      end
      if (r_avalid === 1'b1) begin
        wait_cnt++;
        if (wait_cnt == 1) held_addr = r_addr;
        else if (r_addr !== held_addr) stable_err++;
        if (wait_cnt > aready_delay) begin
          r_aready = 1'b1;
          ack_addr = r_addr;
        end
      end else begin
        if (wait_cnt > 0) stable_err++;
        wait_cnt = 0;
      end
    end
  end

  // Output monitor on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        out_data_log.push_back(out_data);
        out_last_log.push_back(out_last);
        pop_total++;
      end
      if (done === 1'b1) done_cnt++;
      if (acc_total - pop_total > max_occ) max_occ = acc_total - pop_total;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    ack_log.delete();
    out_data_log.delete();
    out_last_log.delete();
    done_cnt  = 0;
    acc_total = 0;
    pop_total = 0;
    max_occ   = 0;
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
    checks++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL cmd_ready_before_cmd: got %b expected 1", cmd_ready);
    end
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (done_cnt == start) begin
      fails++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks += 5;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    if (r_avalid !== 1'b0)  begin fails++; $display("FAIL reset_r_avalid: got %b expected 0", r_avalid); end
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (done !== 1'b0)      begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    if (r_addr !== 4'd0)    begin fails++; $display("FAIL reset_r_addr: got %0d expected 0", r_addr); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_d [3];
    logic [AW-1:0] exp_a [3];
    exp_d[0] = 32'h20; exp_d[1] = 32'h30; exp_d[2] = 32'h40;
    exp_a[0] = 4'd2;   exp_a[1] = 4'd3;   exp_a[2] = 4'd4;
    clear_logs();
    out_ready = 1'b1;
    send_cmd(4'd2, 8'd3);
    wait_done(100);
    repeat (4) tick();
    checks += 3;
    if (out_data_log.size() != 3) begin fails++; $display("FAIL basic_count: got %0d expected 3", out_data_log.size()); end
    if (ack_log.size() != 3)      begin fails++; $display("FAIL basic_acks: got %0d expected 3", ack_log.size()); end
    if (done_cnt != 1)            begin fails++; $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt); end
    if (out_data_log.size() == 3 && ack_log.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks += 3;
        if (out_data_log[i] !== exp_d[i]) begin fails++; $display("FAIL basic_data[%0d]: got %0h expected %0h", i, out_data_log[i], exp_d[i]); end
        if (out_last_log[i] !== (i == 2)) begin fails++; $display("FAIL basic_last[%0d]: got %b expected %b", i, out_last_log[i], (i == 2)); end
        if (ack_log[i] !== exp_a[i])      begin fails++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, ack_log[i], exp_a[i]); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp_d [4];
    logic [AW-1:0] exp_a [4];
    exp_a[0] = 4'd14; exp_a[1] = 4'd15; exp_a[2] = 4'd0; exp_a[3] = 4'd1;
    exp_d[0] = 32'hE0; exp_d[1] = 32'hF0; exp_d[2] = 32'h00; exp_d[3] = 32'h10;
    clear_logs();
    out_ready = 1'b1;
    send_cmd(4'd14, 8'd4);
    wait_done(100);
    checks += 2;
    if (ack_log.size() != 4)      begin fails++; $display("FAIL wrap_acks: got %0d expected 4", ack_log.size()); end
    if (out_data_log.size() != 4) begin fails++; $display("FAIL wrap_count: got %0d expected 4", out_data_log.size()); end
    if (ack_log.size() == 4 && out_data_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks += 3;
        if (ack_log[i] !== exp_a[i])      begin fails++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, ack_log[i], exp_a[i]); end
        if (out_data_log[i] !== exp_d[i]) begin fails++; $display("FAIL wrap_data[%0d]: got %0h expected %0h", i, out_data_log[i], exp_d[i]); end
        if (out_last_log[i] !== (i == 3)) begin fails++; $display("FAIL wrap_last[%0d]: got %b expected %b", i, out_last_log[i], (i == 3)); end
      end
    end
  endtask

  task automatic test_backpressure();
    clear_logs();
    out_ready = 1'b0;
    send_cmd(4'd0, 8'd8);
    repeat (30) tick();
    checks += 3;
    if (ack_log.size() != 4) begin fails++; $display("FAIL bp_acks_held: got %0d expected 4", ack_log.size()); end
    if (r_avalid !== 1'b0)   begin fails++; $display("FAIL bp_avalid_low: got %b expected 0", r_avalid); end
    if (out_valid !== 1'b1)  begin fails++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
    out_ready = 1'b1;
    wait_done(200);
    checks += 3;
    if (ack_log.size() != 8)      begin fails++; $display("FAIL bp_acks_total: got %0d expected 8", ack_log.size()); end
    if (out_data_log.size() != 8) begin fails++; $display("FAIL bp_count: got %0d expected 8", out_data_log.size()); end
    if (max_occ > 4)              begin fails++; $display("FAIL bp_occupancy: got %0d expected <=4", max_occ); end
    if (out_data_log.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        checks += 2;
        if (out_data_log[i] !== 32'(i * 16)) begin fails++; $display("FAIL bp_data[%0d]: got %0h expected %0h", i, out_data_log[i], i * 16); end
        if (out_last_log[i] !== (i == 7))    begin fails++; $display("FAIL bp_last[%0d]: got %b expected %b", i, out_last_log[i], (i == 7)); end
      end
    end
  endtask

  task automatic test_stall();
    logic [AW-1:0] exp_a [3];
    exp_a[0] = 4'd5; exp_a[1] = 4'd6; exp_a[2] = 4'd7;
    clear_logs();
    aready_delay = 5;
    stable_err   = 0;
    out_ready    = 1'b1;
    send_cmd(4'd5, 8'd3);
    wait_done(300);
    aready_delay = 1;
    checks += 3;
    if (stable_err != 0)          begin fails++; $display("FAIL stall_stable: got %0d changes expected 0", stable_err); end
    if (ack_log.size() != 3)      begin fails++; $display("FAIL stall_acks: got %0d expected 3", ack_log.size()); end
    if (out_data_log.size() != 3) begin fails++; $display("FAIL stall_count: got %0d expected 3", out_data_log.size()); end
    if (ack_log.size() == 3 && out_data_log.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks += 2;
        if (ack_log[i] !== exp_a[i]) begin fails++; $display("FAIL stall_addr[%0d]: got %0d expected %0d", i, ack_log[i], exp_a[i]); end
        if (out_data_log[i] !== 32'(80 + i * 16)) begin fails++; $display("FAIL stall_data[%0d]: got %0h expected %0h", i, out_data_log[i], 80 + i * 16); end
      end
    end
  endtask

  task automatic test_len_zero();
    clear_logs();
    out_ready = 1'b1;
    send_cmd(4'd7, 8'd0);
    repeat (6) tick();
    checks += 4;
    if (ack_log.size() != 0)      begin fails++; $display("FAIL len0_acks: got %0d expected 0", ack_log.size()); end
    if (out_data_log.size() != 0) begin fails++; $display("FAIL len0_out: got %0d expected 0", out_data_log.size()); end
    if (done_cnt != 1)            begin fails++; $display("FAIL len0_done: got %0d expected 1", done_cnt); end
    if (cmd_ready !== 1'b1)       begin fails++; $display("FAIL len0_cmd_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_logs();
    ret_delay = 8;
    out_ready = 1'b1;
    send_cmd(4'd3, 8'd6);
    n = 0;
    while (ack_log.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (ack_log.size() < 2) begin fails++; $display("FAIL rmid_accepts: got %0d expected 2", ack_log.size()); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks += 2;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rmid_cmd_ready: got %b expected 1", cmd_ready); end
    if (r_avalid !== 1'b0)  begin fails++; $display("FAIL rmid_avalid: got %b expected 0", r_avalid); end
    repeat (20) tick();
    checks += 3;
    if (out_data_log.size() != 0) begin fails++; $display("FAIL rmid_stray_out: got %0d expected 0", out_data_log.size()); end
    if (done_cnt != 0)            begin fails++; $display("FAIL rmid_done: got %0d expected 0", done_cnt); end
    if (ack_log.size() != 2)      begin fails++; $display("FAIL rmid_no_new_req: got %0d expected 2", ack_log.size()); end
    ret_delay = 1;
    clear_logs();
    send_cmd(4'd9, 8'd2);
    wait_done(100);
    checks++;
    if (out_data_log.size() != 2) begin
      fails++;
      $display("FAIL rmid_new_count: got %0d expected 2", out_data_log.size());
    end else begin
      checks += 3;
      if (out_data_log[0] !== 32'h90) begin fails++; $display("FAIL rmid_new_data0: got %0h expected 90", out_data_log[0]); end
      if (out_data_log[1] !== 32'hA0) begin fails++; $display("FAIL rmid_new_data1: got %0h expected a0", out_data_log[1]); end
      if (out_last_log[1] !== 1'b1)   begin fails++; $display("FAIL rmid_new_last: got %b expected 1", out_last_log[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_stall();
    test_len_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
- Requester-side read engine for one port of the multi-requester shared memory.
- Accepts a burst command (start address, word count) and issues one word request per address on the memory's avalid/aready read port.
- Captures returned words on dvalid into a local FIFO and presents them downstream as a valid/ready stream with a last flag.
- Credit-limited so returned data never overflows the FIFO.

Parameters:
- DATA_WIDTH, 32, memory word width.
- ADDR_WIDTH, 4, memory address width; addresses wrap modulo 2^ADDR_WIDTH.
- LEN_WIDTH, 8, burst length field width.
- FIFO_DEPTH, 4, return FIFO entries; power of 2, >=2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cmd_addr  in  ADDR_WIDTH  burst start address
- cmd_len  in  LEN_WIDTH  burst word count
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- r_addr  out  ADDR_WIDTH  request address to memory port
- r_avalid  out  1  request valid
- r_aready  in  1  request accepted (single-cycle pulse)
- r_dvalid  in  1  returned data valid
- r_data  in  DATA_WIDTH  returned data
- out_data  out  DATA_WIDTH  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_last  out  1  final word of the burst
- done  out  1  one-cycle pulse when the burst completes

Behaviour:
- Reset: one clock, synchronous active-low reset (rst_n sampled on posedge clk; 0 = reset).
  - All outputs 0 except cmd_ready=1.
  - FIFO empty, inflight=0, state IDLE.
- FSM states: IDLE, REQ, DRAIN.
  - IDLE: cmd_ready=1.
    - On a command handshake, latch addr and len.
    - len==0: go to DRAIN with nothing to return; done pulses the next cycle, then IDLE.
    - Otherwise go to REQ.
  - REQ: issue requests.
    - Transition to DRAIN on the acceptance of the last request.
  - DRAIN: wait for all returns to be captured and popped.
    - done=1 for one cycle on the cycle after the out_last handshake; then IDLE.
- Request handshake:
  - r_avalid is registered.
  - Assert r_avalid only when fifo_count + inflight < FIFO_DEPTH.
  - Once asserted, r_avalid and r_addr are held stable until r_aready is sampled high.
  - A request is accepted on the cycle r_avalid && r_aready.
    - That cycle: inflight+1 and remaining-1.
    - Next cycle: r_addr = addr+1 (wraps from 2^ADDR_WIDTH-1 to 0); r_avalid re-evaluated against credit.
- Return capture:
  - r_dvalid && inflight>0: push r_data into the FIFO, inflight-1.
  - r_dvalid with inflight==0 is ignored (covers returns arriving after a reset).
  - Simultaneous accept and return in one cycle: inflight unchanged.
- Stream output:
  - out_valid = FIFO not empty; pop on out_valid && out_ready.
  - Simultaneous push and pop are allowed, including at full and at empty-with-bypass-off.
  - FIFO is never written while full; the credit rule guarantees this.
  - out_last=1 on the word whose stream index equals len-1.
  - Stream order equals request order; the memory returns in order.
- Counters: inflight is width clog2(FIFO_DEPTH)+1. Burst word counter is LEN_WIDTH bits.
- Reset mid-burst: everything is aborted next cycle with no done pulse; later stray dvalid is dropped.

Optional Feature:
- Macro: MEM_BURST_READER_STATS_EN.
- When defined, adds output port stall_cycles, 16 bits, saturating.
  - Counts cycles with r_avalid && !r_aready, plus cycles in REQ blocked by credit.
  - Cleared by reset and on every command handshake.
- When undefined, the port and the counter are absent and behaviour is otherwise identical.

Decomposition:
- Package mem_burst_reader_pkg holds:
  - State enum typedef, state_t {IDLE, REQ, DRAIN}.
  - Function clog2-based width constant for inflight.
- Sub-module sync_fifo (DATA_WIDTH, DEPTH):
  - Signals: push/pop/full/empty/count.
  - Holds the return data and a parallel last bit.

Test Plan:
- Basic burst: cmd addr=2, len=3; memory model aready 1 cycle after avalid, dvalid 1 cycle after aready, data=addr*16; out_ready=1 -> stream 0x20, 0x30, 0x40; out_last on 0x40; done pulses once.
- Wrap: addr=14, len=4, ADDR_WIDTH=4 -> r_addr sequence 14, 15, 0, 1.
- Backpressure: len=8, out_ready=0 -> at most 4 requests accepted, then r_avalid stays 0. Raise out_ready -> remaining 4 issue, all 8 words in order, no FIFO overflow.
- Arbitration stall: aready delayed 5 cycles per request -> r_addr/r_avalid held stable throughout; no duplicate or skipped addresses.
- len=0 command -> no r_avalid, no out_valid, done pulse, cmd_ready back to 1.
- Reset mid-burst: len=6, reset after 2 accepts with 2 dvalid pending, those dvalid arriving after release -> no out_valid, no done; a new burst of len=2 then completes correctly.
